irq_controller_block: RTL and testbench

IRQ_CONTROLLER_BLOCK -- requirements
Module: irq_controller_block

---
 rtl/mips_pkg.sv | 17 +
 rtl/irq_edge_sync.sv | 44 ++++
 rtl/irq_controller_block.sv | 101 ++++++++++
 tb/tb_irq_controller_block.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the interrupt controller: default line count,
// controller state type and the irq id width helper.
package mips_pkg;

    localparam int N_IRQ_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        SERVICE
    } irq_state_t;

    function automatic int irq_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// Per-line rising-edge detector with an optional two-flop input synchronizer
// (enabled by defining IRQ_SYNC_EN).
module irq_edge_sync #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] irq_in,
    output logic [W-1:0] irq_edge
);

    logic [W-1:0] irq_s;
    logic [W-1:0] irq_q;

`ifdef IRQ_SYNC_EN
    logic [W-1:0] sync1;
    logic [W-1:0] sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = irq_in;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= '0;
        end else begin
            irq_q <= irq_s;
        end
    end

    assign irq_edge = irq_s & ~irq_q;

endmodule

// File: rtl/irq_controller_block.sv
// Edge-triggered interrupt controller: pending capture, mask, lowest-index
// priority arbitration and IDLE/FIRE/SERVICE handshake. Optional IRQ_SYNC_EN.
module irq_controller_block
    import mips_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEFAULT
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_IRQ-1:0]                irq_in,
    input  logic                            mask_wr,
    input  logic [N_IRQ-1:0]                mask_data,
    input  logic                            ack,
    output logic                            interrupt,
    output logic [irq_id_width(N_IRQ)-1:0]  irq_id,
    output logic [N_IRQ-1:0]                pending,
    output logic                            in_service
);

    localparam int IW = irq_id_width(N_IRQ);

    irq_state_t       state;
    irq_state_t       state_n;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] irq_edge;
    logic [N_IRQ-1:0] active;
    logic [N_IRQ-1:0] clr;
    logic [IW-1:0]    sel_id;
    logic             found;
    logic             load_id;

    irq_edge_sync #(
        .W(N_IRQ)
    ) u_edge_sync (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in),
        .irq_edge (irq_edge)
    );

    assign active = pending & mask;

    always_comb begin
        sel_id = '0;
        found  = 1'b0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (active[i] && !found) begin
                sel_id = IW'(i);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n    = state;
        interrupt  = 1'b0;
        in_service = 1'b0;
        clr        = '0;
        load_id    = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load_id = 1'b1;
                    state_n = FIRE;
                end
            end
            FIRE: begin
                interrupt = 1'b1;
                clr       = N_IRQ'(1) << irq_id;
                state_n   = SERVICE;
            end
            SERVICE: begin
                in_service = 1'b1;
                if (ack) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pending <= '0;
            mask    <= '1;
            irq_id  <= '0;
        end else begin
            state <= state_n;
            // A new edge on the line being cleared keeps it pending.
            pending <= (pending & ~clr) | irq_edge;
            if (mask_wr) begin
                mask <= mask_data;
            end
            if (load_id) begin
                irq_id <= sel_id;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller_block.sv
// Self-checking bench for irq_controller_block (N_IRQ = 4): directed scenarios
// followed by random traffic, all checked against a cycle-level reference model.
module tb_irq_controller_block;

    logic       clk;
    logic       reset;
    logic [3:0] irq_in;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       ack;
    logic       interrupt;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic       in_service;

    int n_cmp = 0;
    int n_err = 0;

`ifdef IRQ_SYNC_EN
    localparam int FIRE_TICKS = 4;
`else
    localparam int FIRE_TICKS = 2;
`endif

    irq_controller_block #(
        .N_IRQ(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .ack        (ack),
        .interrupt  (interrupt),
        .irq_id     (irq_id),
        .pending    (pending),
        .in_service (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: lines seen by the controller, pending set, mask,
    // and whether an interrupt is firing or awaiting ack.
    bit [3:0] m_prev, m_pend, m_mask, m_s1, m_s2, m_line, m_new, m_elig;
    int       m_id;
    bit       m_fire, m_busy;

    task automatic model_reset();
        m_prev = '0; m_pend = '0; m_mask = 4'hF; m_s1 = '0; m_s2 = '0;
        m_id = 0; m_fire = 0; m_busy = 0;
    endtask

    always @(posedge clk) begin
        if (reset) begin
`ifdef IRQ_SYNC_EN
            m_line = m_s2;
            m_s2   = m_s1;
            m_s1   = irq_in;
`else
            m_line = irq_in;
`endif
            m_new  = m_line & ~m_prev;
            m_prev = m_line;
            m_elig = m_pend & m_mask;
            if (m_fire) begin
                m_pend[m_id] = 1'b0;
                m_fire = 0;
                m_busy = 1;
            end else if (m_busy) begin
                if (ack) m_busy = 0;
            end else if (m_elig != 0) begin
                for (int i = 3; i >= 0; i--)
                    if (m_elig[i]) m_id = i;
                m_fire = 1;
            end
            m_pend = m_pend | m_new;
            if (mask_wr) m_mask = mask_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("interrupt", {31'b0, interrupt}, {31'b0, m_fire});
        chk("in_service", {31'b0, in_service}, {31'b0, m_busy});
        chk("irq_id", {30'b0, irq_id}, m_id);
        chk("pending", {28'b0, pending}, {28'b0, m_pend});
    endtask

    task automatic apply_reset();
        #2;
        reset = 1'b0;
        irq_in = '0; ack = 0; mask_wr = 0; mask_data = '0;
        model_reset();
        #1;
        chk("rst_interrupt", {31'b0, interrupt}, 0);
        chk("rst_in_service", {31'b0, in_service}, 0);
        chk("rst_pending", {28'b0, pending}, 0);
        chk("rst_irq_id", {30'b0, irq_id}, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Ticks until interrupt is seen; returns tick count or -1 on timeout.
    task automatic wait_irq(input int limit, output int n);
        n = -1;
        for (int t = 1; t <= limit; t++) begin
            tick();
            if (interrupt === 1'b1) begin
                n = t;
                break;
            end
        end
    endtask

    task automatic do_ack();
        ack = 1; tick(); ack = 0;
    endtask

    initial begin
        int n;
        reset = 1'b1; irq_in = '0; mask_wr = 0; mask_data = '0; ack = 0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Scenario 1: single request on line 0
        repeat (9) tick();
        irq_in = 4'b0001;
        wait_irq(10, n);
        chk("s1_latency", n, FIRE_TICKS);
        chk("s1_id", {30'b0, irq_id}, 0);
        chk("s1_pending_at_fire", {28'b0, pending}, 4'b0001);
        tick();
        chk("s1_in_service", {31'b0, in_service}, 1);
        repeat (3) tick();
        do_ack();
        tick();
        chk("s1_idle_after_ack", {31'b0, in_service}, 0);
        irq_in = '0;
        repeat (3) tick();

        // Scenario 2: simultaneous requests, lowest index first
        irq_in = 4'b1010;
        wait_irq(10, n);
        chk("s2_first_seen", {31'b0, n > 0}, 1);
        chk("s2_first_id", {30'b0, irq_id}, 1);
        tick();
        chk("s2_pending", {28'b0, pending}, 4'b1000);
        do_ack();
        wait_irq(10, n);
        chk("s2_second_seen", {31'b0, n > 0}, 1);
        chk("s2_second_id", {30'b0, irq_id}, 3);
        tick();
        do_ack();
        irq_in = '0;
        repeat (3) tick();

        // Scenario 3: masked line stays pending until unmasked
        mask_wr = 1; mask_data = 4'b1110; tick(); mask_wr = 0;
        irq_in = 4'b0001;
        repeat (8) tick();
        chk("s3_masked_pending", {28'b0, pending}, 4'b0001);
        chk("s3_masked_no_irq", {31'b0, interrupt}, 0);
        mask_wr = 1; mask_data = 4'b1111; tick(); mask_wr = 0;
        wait_irq(2, n);
        chk("s3_unmask_fire", {31'b0, n > 0}, 1);
        chk("s3_unmask_id", {30'b0, irq_id}, 0);
        tick();
        do_ack();
        irq_in = '0;
        repeat (3) tick();

        // Scenario 4: second edge on line 2 lands in its FIRE cycle
        irq_in = 4'b0100;
`ifdef IRQ_SYNC_EN
        repeat (2) tick();
`endif
        tick();
        irq_in = 4'b0000;
        tick();
        chk("s4_fire", {31'b0, interrupt}, 1);
        chk("s4_fire_id", {30'b0, irq_id}, 2);
        irq_in = 4'b0100;
`ifdef IRQ_SYNC_EN
        // Edge is seen two cycles later through the synchronizer; the
        // collision case is exercised only without it.
`endif
        tick();
`ifndef IRQ_SYNC_EN
        chk("s4_set_wins", {28'b0, pending}, 4'b0100);
`endif
        chk("s4_service", {31'b0, in_service}, 1);
        repeat (4) tick();
        do_ack();
        wait_irq(10, n);
        chk("s4_refire", {31'b0, n > 0}, 1);
        tick();
        do_ack();
        irq_in = '0;
        repeat (3) tick();

        // Scenario 5: reset during SERVICE with line 2 pending
        irq_in = 4'b0001;
        wait_irq(10, n);
        tick();
        irq_in = 4'b0101;
        repeat (FIRE_TICKS) tick();
        chk("s5_service", {31'b0, in_service}, 1);
        chk("s5_pending", {28'b0, pending}, 4'b0100);
        apply_reset();
        for (int t = 0; t < 20; t++) begin
            tick();
            chk("s5_quiet", {31'b0, interrupt}, 0);
        end

        // Random traffic
        for (int t = 0; t < 600; t++) begin
            irq_in    = 4'($urandom);
            ack       = ($urandom_range(0, 3) == 0);
            mask_wr   = ($urandom_range(0, 15) == 0);
            mask_data = 4'($urandom);
            tick();
        end
        ack = 0; mask_wr = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
